// File: rtl/gnr_attractor_ctrl.sv
// Floyd cycle-finding controller for a bank of GNR node cells: races tortoise/hare copies,
// then measures the attractor period and hands {meet, period, state} to the host.
module gnr_attractor_ctrl #(
    parameter int N_NODES   = 8,
    parameter int CNT_W     = 16,
    parameter int MAX_STEPS = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_NODES-1:0] init_vec,
    input  logic [N_NODES-1:0] s0_vec,
    input  logic [N_NODES-1:0] s1_vec,
    output logic               reset_nos,
    output logic [N_NODES-1:0] init_state,
    output logic               start_s0,
    output logic               start_s1,
    output logic               busy,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [CNT_W-1:0]   res_meet,
    output logic [CNT_W-1:0]   res_period,
    output logic [N_NODES-1:0] res_state,
    output logic               res_timeout
);

    // state  | meaning
    // IDLE   | waiting for start
    // LOAD   | one cycle loading init_state into every node
    // RACE   | tortoise at half rate, hare at full rate, compare on even c >= 2
    // PERIOD | hare alone walks the cycle until it returns to res_state
    // RESULT | result held on res_* until the host handshakes
    typedef enum logic [2:0] {IDLE, LOAD, RACE, PERIOD, RESULT} state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_STEPS);

    state_t           state;
    logic [CNT_W-1:0] c_cnt;
    logic [CNT_W-1:0] p_cnt;
    logic             meet_now;
    logic             race_to;
    logic             hit_now;
    logic             period_to;

    // c[0] tracks the node pass bit, so even c means tortoise has exactly c/2 steps
    assign meet_now  = (state == RACE) && !c_cnt[0] && (c_cnt >= CNT_W'(2)) && (s0_vec == s1_vec);
    assign race_to   = (state == RACE) && (c_cnt >= MAX_CNT);
    assign hit_now   = (state == PERIOD) && (p_cnt != '0) && (s1_vec == res_state);
    assign period_to = (state == PERIOD) && (p_cnt >= MAX_CNT);

    // Node steps are suppressed in the cycle a decision is made so captured state stays valid
    assign start_s0  = (state == RACE) && !meet_now && !race_to;
    assign start_s1  = start_s0 || ((state == PERIOD) && !hit_now && !period_to);
    assign reset_nos = (state == LOAD);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            c_cnt       <= '0;
            p_cnt       <= '0;
            init_state  <= '0;
            res_valid   <= 1'b0;
            res_meet    <= '0;
            res_period  <= '0;
            res_state   <= '0;
            res_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        init_state  <= init_vec;
                        res_meet    <= '0;
                        res_period  <= '0;
                        res_state   <= '0;
                        res_timeout <= 1'b0;
                        state       <= LOAD;
                    end
                end
                LOAD: begin
                    c_cnt <= '0;
                    p_cnt <= '0;
                    state <= RACE;
                end
                RACE: begin
                    if (meet_now) begin
                        res_meet  <= c_cnt;
                        res_state <= s0_vec;
                        p_cnt     <= '0;
                        state     <= PERIOD;
                    end else if (race_to) begin
                        res_meet    <= c_cnt;
                        res_period  <= '0;
                        res_timeout <= 1'b1;
                        res_valid   <= 1'b1;
                        state       <= RESULT;
                    end else begin
                        c_cnt <= c_cnt + CNT_W'(1);
                    end
                end
                PERIOD: begin
                    if (hit_now) begin
                        res_period <= p_cnt;
                        res_valid  <= 1'b1;
                        state      <= RESULT;
                    end else if (period_to) begin
                        res_period  <= '0;
                        res_timeout <= 1'b1;
                        res_valid   <= 1'b1;
                        state       <= RESULT;
                    end else begin
                        p_cnt <= p_cnt + CNT_W'(1);
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// Directed bench for gnr_attractor_ctrl: a behavioural node bank with selectable next-state
// functions stands in for the GNR cells.
module tb_gnr_attractor_ctrl;

    localparam int NN = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [NN-1:0] init_vec = '0;
    logic [NN-1:0] s0_vec = '0;
    logic [NN-1:0] s1_vec = '0;
    logic          reset_nos;
    logic [NN-1:0] init_state;
    logic          start_s0;
    logic          start_s1;
    logic          busy;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [CW-1:0] res_meet;
    logic [CW-1:0] res_period;
    logic [NN-1:0] res_state;
    logic          res_timeout;

    int n_chk = 0;
    int n_pass = 0;
    int model_sel = 0;
    logic pass_bit = 1'b0;

    gnr_attractor_ctrl #(.N_NODES(NN), .CNT_W(CW), .MAX_STEPS(16)) dut (
        .clk(clk), .rst(rst), .start(start), .init_vec(init_vec),
        .s0_vec(s0_vec), .s1_vec(s1_vec), .reset_nos(reset_nos), .init_state(init_state),
        .start_s0(start_s0), .start_s1(start_s1), .busy(busy), .res_valid(res_valid),
        .res_ready(res_ready), .res_meet(res_meet), .res_period(res_period),
        .res_state(res_state), .res_timeout(res_timeout)
    );

    always #5 clk = ~clk;

    // 0: 3-bit ring (period 3), 1: fixed point, 2: 10->11 then 20..23 loop, 3: mod-40 counter
    function automatic logic [NN-1:0] next_of(input int sel, input logic [NN-1:0] x);
        case (sel)
            0: next_of = {5'b0, x[1:0], x[2]};
            1: next_of = x;
            2: case (x)
                   8'h10: next_of = 8'h11;
                   8'h11: next_of = 8'h20;
                   8'h20: next_of = 8'h21;
                   8'h21: next_of = 8'h22;
                   8'h22: next_of = 8'h23;
                   8'h23: next_of = 8'h20;
                   default: next_of = x;
               endcase
            default: next_of = (x == 8'd39) ? 8'd0 : x + 8'd1;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset_nos) begin
            s0_vec   <= init_state;
            s1_vec   <= init_state;
            pass_bit <= 1'b1;
        end else begin
            if (start_s1) s1_vec <= next_of(model_sel, s1_vec);
            if (start_s0) begin
                if (pass_bit) s0_vec <= next_of(model_sel, s0_vec);
                pass_bit <= ~pass_bit;
            end
        end
    end

    // Returns at the negedge of the LOAD cycle.
    task automatic do_start(input logic [NN-1:0] iv);
        @(negedge clk);
        init_vec = iv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_result(input int budget, output int cycles, output bit ok);
        cycles = 0;
        ok = 1'b0;
        while (cycles < budget) begin
            if (res_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic release_result();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++; if ({busy, res_valid, reset_nos, start_s0, start_s1, res_timeout} !== 6'b0)
            $display("FAIL reset_ctl: got %b want 000000", {busy, res_valid, reset_nos, start_s0, start_s1, res_timeout});
        else n_pass++;
        n_chk++; if ({res_meet, res_period, res_state, init_state} !== '0)
            $display("FAIL reset_res: got %h want 0", {res_meet, res_period, res_state, init_state});
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ring();
        int cyc;
        bit ok;
        model_sel = 0;
        do_start(8'h01);
        n_chk++; if (reset_nos !== 1'b1 || init_state !== 8'h01)
            $display("FAIL ring_load: got reset_nos=%b init=%h want 1 01", reset_nos, init_state);
        else n_pass++;
        wait_result(200, cyc, ok);
        n_chk++; if (!ok) $display("FAIL ring_done: res_valid never rose within 200 cycles");
        else n_pass++;
        // LOAD + RACE c=0..6 + PERIOD p=0..3
        n_chk++; if (cyc !== 12) $display("FAIL ring_latency: got %0d want 12", cyc);
        else n_pass++;
        n_chk++; if (res_meet !== 16'd6) $display("FAIL ring_meet: got %0d want 6", res_meet);
        else n_pass++;
        n_chk++; if (res_period !== 16'd3) $display("FAIL ring_period: got %0d want 3", res_period);
        else n_pass++;
        n_chk++; if (res_state !== 8'h01 || res_timeout !== 1'b0)
            $display("FAIL ring_state: got %h/%b want 01/0", res_state, res_timeout);
        else n_pass++;
        release_result();
        n_chk++; if (busy !== 1'b0 || res_valid !== 1'b0)
            $display("FAIL ring_release: got busy=%b valid=%b want 0 0", busy, res_valid);
        else n_pass++;
    endtask

    task automatic test_fixed_point();
        int cyc;
        bit ok;
        model_sel = 1;
        do_start(8'hA5);
        wait_result(200, cyc, ok);
        n_chk++; if (!ok) $display("FAIL fixed_done: res_valid never rose within 200 cycles");
        else n_pass++;
        n_chk++; if (res_meet !== 16'd2 || res_period !== 16'd1)
            $display("FAIL fixed_meet_period: got %0d/%0d want 2/1", res_meet, res_period);
        else n_pass++;
        n_chk++; if (res_state !== 8'hA5 || res_timeout !== 1'b0)
            $display("FAIL fixed_state: got %h/%b want a5/0", res_state, res_timeout);
        else n_pass++;
        release_result();
    endtask

    // Tortoise reaches 22 after 4 steps while the hare has 8 steps (also 22): meet at c=8.
    task automatic test_transient();
        int cyc;
        bit ok;
        model_sel = 2;
        do_start(8'h10);
        wait_result(200, cyc, ok);
        n_chk++; if (!ok) $display("FAIL trans_done: res_valid never rose within 200 cycles");
        else n_pass++;
        n_chk++; if (res_meet !== 16'd8) $display("FAIL trans_meet: got %0d want 8", res_meet);
        else n_pass++;
        n_chk++; if (res_period !== 16'd4) $display("FAIL trans_period: got %0d want 4", res_period);
        else n_pass++;
        n_chk++; if (res_state !== 8'h22) $display("FAIL trans_state: got %h want 22", res_state);
        else n_pass++;
        release_result();
    endtask

    task automatic test_timeout();
        int cyc;
        bit ok;
        model_sel = 3;
        do_start(8'h00);
        wait_result(200, cyc, ok);
        n_chk++; if (!ok) $display("FAIL to_done: res_valid never rose within 200 cycles");
        else n_pass++;
        // LOAD + RACE c=0..16
        n_chk++; if (cyc !== 18) $display("FAIL to_latency: got %0d want 18", cyc);
        else n_pass++;
        n_chk++; if (res_timeout !== 1'b1 || res_meet !== 16'd16 || res_period !== 16'd0)
            $display("FAIL to_result: got to=%b meet=%0d per=%0d want 1 16 0", res_timeout, res_meet, res_period);
        else n_pass++;
        release_result();
    endtask

    task automatic test_reset_mid_race();
        model_sel = 0;
        do_start(8'h01);
        repeat (6) @(negedge clk);
        n_chk++; if (start_s0 !== 1'b1 || busy !== 1'b1)
            $display("FAIL midrst_pre: got s0=%b busy=%b want 1 1", start_s0, busy);
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_chk++; if ({busy, res_valid, start_s0, start_s1, reset_nos} !== 5'b0)
            $display("FAIL midrst_post: got %b want 00000", {busy, res_valid, start_s0, start_s1, reset_nos});
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit ok;
        bit stable = 1'b1;
        model_sel = 0;
        do_start(8'h01);
        wait_result(200, cyc, ok);
        n_chk++; if (!ok) $display("FAIL b2b_done: res_valid never rose within 200 cycles");
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            start = (i == 4);
            init_vec = 8'hFF;
            @(negedge clk);
            if (res_valid !== 1'b1 || busy !== 1'b1 || res_meet !== 16'd6 || res_period !== 16'd3
                || res_state !== 8'h01 || init_state !== 8'h01 || reset_nos !== 1'b0)
                stable = 1'b0;
        end
        start = 1'b0;
        n_chk++; if (stable !== 1'b1) $display("FAIL b2b_hold: got stable=%b want 1", stable);
        else n_pass++;
        res_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        start = 1'b0;
        n_chk++; if (busy !== 1'b0 || res_valid !== 1'b0)
            $display("FAIL b2b_idle: got busy=%b valid=%b want 0 0", busy, res_valid);
        else n_pass++;
        @(negedge clk);
        n_chk++; if (busy !== 1'b0 || reset_nos !== 1'b0)
            $display("FAIL b2b_ignored: got busy=%b reset_nos=%b want 0 0", busy, reset_nos);
        else n_pass++;
        do_start(8'h02);
        n_chk++; if (reset_nos !== 1'b1 || init_state !== 8'h02)
            $display("FAIL b2b_load: got reset_nos=%b init=%h want 1 02", reset_nos, init_state);
        else n_pass++;
        @(negedge clk);
        n_chk++; if (reset_nos !== 1'b0 || start_s0 !== 1'b1)
            $display("FAIL b2b_race: got reset_nos=%b s0=%b want 0 1", reset_nos, start_s0);
        else n_pass++;
        wait_result(200, cyc, ok);
        n_chk++; if (!ok || res_meet !== 16'd6 || res_state !== 8'h02)
            $display("FAIL b2b_second: got ok=%b meet=%0d state=%h want 1 6 02", ok, res_meet, res_state);
        else n_pass++;
        release_result();
    endtask

    initial begin
        test_reset();
        test_ring();
        test_fixed_point();
        test_transient();
        test_timeout();
        test_reset_mid_race();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
